// File: rtl/key_debounce_pulse_pkg.sv
// Shared types and constants for the five-key debounce and pulse front end.
package key_debounce_pulse_pkg;

    localparam int NUM_KEYS                = 5;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    typedef enum logic [2:0] {
        KEY_NONE = 3'd0,
        KEY_1    = 3'd1,
        KEY_2    = 3'd2,
        KEY_3    = 3'd3,
        KEY_4    = 3'd4,
        KEY_5    = 3'd5
    } key_id_t;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    // Index of the lowest-numbered set key; K1 wins over every other key.
    function automatic key_id_t first_key(input logic [NUM_KEYS-1:0] keys);
        key_id_t id;
        id = KEY_NONE;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (keys[i]) id = key_id_t'(3'(i + 1));
        end
        return id;
    endfunction

endpackage

// File: rtl/key_debounce_pulse_bit.sv
// Two-flop synchronizer plus counter-based debouncer for one raw button.
module key_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_db
);

    localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; the synchronizer chain relies on this.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_db   <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            if (r_sync == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == LP_CNT_MAX) begin
                r_db  <= r_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/key_debounce_pulse.sv
// Five-key front end: per-key debounce, K1-first priority pick, and a
// press/release lockout FSM that emits one single-cycle pulse per press.
module key_debounce_pulse
    import key_debounce_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NUM_KEYS-1:0] KEY_RAW,
    output logic                K1,
    output logic                K2,
    output logic                K3,
    output logic                K4,
    output logic                K5,
    output logic                KEY_VALID,
    output logic [2:0]          KEY_ID,
    output logic                BUSY
);

    logic [NUM_KEYS-1:0] w_db;
    logic [NUM_KEYS-1:0] w_first_hot;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .i_clk (CLK),
            .i_rst (RST),
            .i_raw (KEY_RAW[g]),
            .o_db  (w_db[g])
        );
    end

    // Isolates the lowest set bit, giving the K1-first one-hot choice.
    assign w_first_hot = w_db & (~w_db + 5'd1);

    state_t              r_state;
    logic [NUM_KEYS-1:0] r_pulse;
    logic                r_valid;
    key_id_t             r_key_id;
    logic                r_busy;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_pulse  <= '0;
            r_valid  <= 1'b0;
            r_key_id <= KEY_NONE;
            r_busy   <= 1'b0;
        end else begin
            r_pulse <= '0;
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|w_db) begin
                        r_pulse  <= w_first_hot;
                        r_valid  <= 1'b1;
                        r_key_id <= first_key(w_db);
                        r_state  <= HELD;
                        r_busy   <= 1'b1;
                    end
                end
                HELD: begin
                    // Other presses while held are dropped, not queued.
                    if (w_db == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign K1        = r_pulse[0];
    assign K2        = r_pulse[1];
    assign K3        = r_pulse[2];
    assign K4        = r_pulse[3];
    assign K5        = r_pulse[4];
    assign KEY_VALID = r_valid;
    assign KEY_ID    = r_key_id;
    assign BUSY      = r_busy;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Self-checking bench for key_debounce_pulse with a behavioural model.
module tb_key_debounce_pulse;

    localparam int TB_D = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [4:0] KEY_RAW = 5'b0;
    logic       K1, K2, K3, K4, K5, KEY_VALID, BUSY;
    logic [2:0] KEY_ID;

    key_debounce_pulse #(
        .DEBOUNCE_CYCLES (TB_D),
        .CNT_W           (3)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .KEY_RAW   (KEY_RAW),
        .K1        (K1),
        .K2        (K2),
        .K3        (K3),
        .K4        (K4),
        .K5        (K5),
        .KEY_VALID (KEY_VALID),
        .KEY_ID    (KEY_ID),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt[5];
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: db flips once the last TB_D synchronized samples all disagree
    // with it; a single pulse per press, then locked until everything is up.
    logic [4:0] m_s1, m_s2, m_db, m_pulse;
    logic [4:0] m_hist[$];
    logic [2:0] m_id;
    bit         m_held, m_valid, m_busy;

    always @(posedge CLK) begin
        if (RST) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_pulse = '0;
            m_id = '0; m_held = 0; m_valid = 0;
            m_hist.delete();
        end else begin
            bit found;
            m_pulse = '0;
            m_valid = 0;
            if (!m_held) begin
                if (m_db != 0) begin
                    found = 0;
                    for (int k = 0; k < 5; k++) begin
                        if (m_db[k] && !found) begin
                            m_pulse[k] = 1'b1;
                            m_id = 3'(k + 1);
                            found = 1;
                        end
                    end
                    m_valid = 1;
                    m_held  = 1;
                end
            end else if (m_db == 0) begin
                m_held = 0;
            end
            m_hist.push_back(m_s2);
            if (m_hist.size() > TB_D) void'(m_hist.pop_front());
            if (m_hist.size() == TB_D) begin
                for (int k = 0; k < 5; k++) begin
                    bit all_diff;
                    all_diff = 1;
                    foreach (m_hist[j]) if (m_hist[j][k] == m_db[k]) all_diff = 0;
                    if (all_diff) m_db[k] = ~m_db[k];
                end
            end
            m_s2 = m_s1;
            m_s1 = KEY_RAW;
        end
        m_busy = m_held;
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("cycle_compare",
                  {20'd0, K5, K4, K3, K2, K1, KEY_VALID, KEY_ID, BUSY},
                  {20'd0, m_pulse, m_valid, m_id, m_busy});
            if (K1) pulse_cnt[0]++;
            if (K2) pulse_cnt[1]++;
            if (K3) pulse_cnt[2]++;
            if (K4) pulse_cnt[3]++;
            if (K5) pulse_cnt[4]++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 5; k++) pulse_cnt[k] = 0;
    endtask

    initial begin
        RST = 1'b1;
        KEY_RAW = 5'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        RST = 1'b0;
        check("reset_outputs", {23'd0, K5, K4, K3, K2, K1, KEY_VALID, BUSY}, 32'd0);
        check("reset_key_id", {29'd0, KEY_ID}, 32'd0);

        // Glitch shorter than the debounce window.
        clear_counts();
        KEY_RAW = 5'b00001;
        repeat (3) tick();
        KEY_RAW = 5'b0;
        repeat (12) tick();
        check("glitch_no_pulse", pulse_cnt[0], 0);
        check("glitch_key_id", {29'd0, KEY_ID}, 32'd0);
        check("glitch_busy", {31'd0, BUSY}, 32'd0);

        // Clean press of K3: pulse in the cycle after edge 6.
        clear_counts();
        KEY_RAW = 5'b00100;
        repeat (6) tick();
        check("clean_before_edge6", {31'd0, K3}, 32'd0);
        tick();
        check("clean_k3_pulse", {30'd0, K3, KEY_VALID}, 32'd3);
        check("clean_key_id", {29'd0, KEY_ID}, 32'd3);
        tick();
        check("clean_one_cycle", {30'd0, K3, BUSY}, 32'd1);
        repeat (12) tick();
        KEY_RAW = 5'b0;
        repeat (14) tick();
        check("clean_released", {28'd0, KEY_ID, BUSY}, 32'd6);
        check("clean_pulse_count", pulse_cnt[2], 1);

        // Simultaneous K2+K5: only K2.
        clear_counts();
        KEY_RAW = 5'b10010;
        repeat (7) tick();
        check("simul_k2", {30'd0, K2, K5}, 32'd2);
        check("simul_key_id", {29'd0, KEY_ID}, 32'd2);
        repeat (8) tick();
        KEY_RAW = 5'b0;
        repeat (14) tick();
        check("simul_k5_never", pulse_cnt[4], 0);
        check("simul_k2_once", pulse_cnt[1], 1);

        // Lockout: K4 pressed while K1 held is dropped.
        clear_counts();
        KEY_RAW = 5'b00001;
        repeat (10) tick();
        KEY_RAW = 5'b01001;
        repeat (10) tick();
        KEY_RAW = 5'b00001;
        repeat (3) tick();
        KEY_RAW = 5'b0;
        repeat (14) tick();
        check("lock_k1_once", pulse_cnt[0], 1);
        check("lock_k4_dropped", pulse_cnt[3], 0);
        check("lock_key_id", {29'd0, KEY_ID}, 32'd1);
        KEY_RAW = 5'b01000;
        repeat (10) tick();
        check("lock_fresh_k4", pulse_cnt[3], 1);
        check("lock_fresh_id", {29'd0, KEY_ID}, 32'd4);
        KEY_RAW = 5'b0;
        repeat (14) tick();

        // Bounce on K2, then stable.
        clear_counts();
        for (int i = 0; i < 6; i++) begin
            KEY_RAW = (i % 2 == 0) ? 5'b00010 : 5'b00000;
            tick();
        end
        KEY_RAW = 5'b00010;
        repeat (6) tick();
        check("bounce_before", {31'd0, K2}, 32'd0);
        tick();
        check("bounce_pulse", {31'd0, K2}, 32'd1);
        repeat (6) tick();
        KEY_RAW = 5'b0;
        repeat (14) tick();
        check("bounce_once", pulse_cnt[1], 1);

        // Reset at edge 4 of a K5 press restarts the debounce.
        clear_counts();
        KEY_RAW = 5'b10000;
        repeat (4) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rst_mid_outputs", {23'd0, K5, K4, K3, K2, K1, KEY_VALID, BUSY}, 32'd0);
        check("rst_mid_key_id", {29'd0, KEY_ID}, 32'd0);
        repeat (6) tick();
        check("rst_before_edge11", {31'd0, K5}, 32'd0);
        tick();
        check("rst_k5_pulse", {28'd0, K5, KEY_ID}, 32'h0D);
        KEY_RAW = 5'b0;
        repeat (14) tick();
        check("rst_k5_once", pulse_cnt[4], 1);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
